// File: rtl/program_loader_if.sv
// ============================================================================
// Module      : program_loader_if
// Description : Byte stream and memory write port bundle for program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface program_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // The loader consumes the stream and drives the memory write port.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/program_loader.sv
// ============================================================================
// Module      : program_loader
// Description : Boot loader filling program memory from a byte stream, then
//               releasing the controller from reset. Optional trailing
//               checksum enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module program_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           start,
    program_loader_if.slave     bus,
    output logic                cpu_rst,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CSUM = 3'd3,
        ST_ERR  = 3'd5,
`endif
        ST_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                in_ready_q, in_ready_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                xfer;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic                err_q, err_d;
`endif

    assign xfer = bus.in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        addr_d      = addr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (xfer) begin
                    // A length of zero wraps the down-counter to a full-depth load.
                    count_d = ADDR_W'(bus.in_data);
                    addr_d  = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
`endif
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = bus.in_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    count_d     = count_q - ADDR_W'(1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + bus.in_data;
                    if (count_q == ADDR_W'(1)) state_d = ST_CSUM;
`else
                    if (count_q == ADDR_W'(1)) state_d = ST_DONE;
`endif
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) state_d = (bus.in_data == sum_q) ? ST_DONE : ST_ERR;
            end
            ST_ERR: begin
                if (start) state_d = ST_LEN;
            end
`endif
            ST_DONE: begin
                if (start) state_d = ST_LEN;
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered decodes of the next state.
        in_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     || (state_d == ST_CSUM)
`endif
                     ;
        done_d    = (state_d == ST_DONE);
        cpu_rst_d = (state_d == ST_DONE);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        err_d     = (state_d == ST_ERR);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            addr_q      <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b0;
            done_q      <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rst_q   <= cpu_rst_d;
            done_q      <= done_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum_q       <= sum_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign cpu_rst       = cpu_rst_q;
    assign done          = done_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// Module      : tb_program_loader
// Description : Directed self-checking bench for program_loader with a write
//               scoreboard; follows PROGRAM_LOADER_CHECKSUM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_program_loader;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic cpu_rst, done, err;

    program_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int writes = 0;
    logic [15:0] sb[$];
    logic [7:0] exp_addr = 8'h00;
    logic [7:0] run_sum = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write strobe must match the oldest expected (address, data) pair.
    always @(negedge clk) begin
        logic [15:0] e;
        if (bus.mem_we === 1'b1) begin
            chk("write_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("write_addr", 32'(bus.mem_addr), 32'(e[15:8]));
                chk("write_data", 32'(bus.mem_wdata), 32'(e[7:0]));
                writes++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit is_data, output int stalls);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        stalls = 0;
        while (bus.in_ready !== 1'b1 && stalls < 50) begin
            @(posedge clk); #1;
            stalls++;
        end
        if (bus.in_ready !== 1'b1) begin
            chk("ready_timeout", 32'(bus.in_ready), 32'd1);
        end else begin
            if (is_data) begin
                sb.push_back({exp_addr, b});
                exp_addr = exp_addr + 8'd1;
                run_sum  = run_sum + b;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic gap(input int n);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_start();
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_state", {29'd0, bus.in_ready, cpu_rst, done}, {29'd0, 3'b100});
        chk("start_err", 32'(err), 32'd0);
        exp_addr = 8'h00;
        run_sum  = 8'h00;
        writes   = 0;
    endtask

    initial begin
        int s;
        int total;
        logic [7:0] b;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_values", {11'd0, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, done, err}, 32'd0);
        rst = 1'b1;

        // Idle with no start: everything stays low.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_outputs", {11'd0, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, done, err}, 32'd0);
        end

        // Full-depth load (L = 0), data equals address, back to back.
        do_start();
        total = 0;
        send_byte(8'h00, 1'b0, s); total += s;
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i), 1'b1, s); total += s;
        end
        chk("full_load_stalls", 32'(total), 32'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        chk("last_write", {23'd0, bus.mem_we, bus.mem_addr}, {23'd0, 1'b1, 8'hFF});
        send_byte(run_sum, 1'b0, s);
        chk("full_csum_stalls", 32'(s), 32'd0);
`else
        chk("last_write", {23'd0, bus.mem_we, bus.mem_addr}, {23'd0, 1'b1, 8'hFF});
`endif
        bus.in_valid = 1'b0;
        chk("full_done", {29'd0, done, cpu_rst, bus.in_ready}, {29'd0, 3'b110});
        gap(3);
        chk("full_write_count", 32'(writes), 32'd256);
        chk("full_sb_empty", 32'(sb.size()), 32'd0);
        chk("full_done_hold", {30'd0, done, cpu_rst}, {30'd0, 2'b11});

        // Reload from DONE with random gaps in in_valid.
        do_start();
        send_byte(8'd7, 1'b0, s);
        for (int i = 0; i < 7; i++) begin
            gap($urandom_range(0, 2));
            b = 8'($urandom);
            send_byte(b, 1'b1, s);
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        gap($urandom_range(0, 2));
        send_byte(run_sum, 1'b0, s);
`endif
        bus.in_valid = 1'b0;
        chk("gappy_done", {29'd0, done, cpu_rst, bus.in_ready}, {29'd0, 3'b110});
        gap(2);
        chk("gappy_write_count", 32'(writes), 32'd7);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Good checksum stream.
        do_start();
        total = 0;
        send_byte(8'h03, 1'b0, s); total += s;
        send_byte(8'h11, 1'b1, s); total += s;
        send_byte(8'h22, 1'b1, s); total += s;
        send_byte(8'h33, 1'b1, s); total += s;
        send_byte(8'h66, 1'b0, s); total += s;
        bus.in_valid = 1'b0;
        chk("csum_ok_stalls", 32'(total), 32'd0);
        chk("csum_ok_done", {28'd0, done, cpu_rst, bus.in_ready, err}, {28'd0, 4'b1100});
        gap(2);

        // Bad checksum stream, then recovery.
        do_start();
        send_byte(8'h02, 1'b0, s);
        send_byte(8'h0A, 1'b1, s);
        send_byte(8'h0B, 1'b1, s);
        send_byte(8'h00, 1'b0, s);
        bus.in_valid = 1'b0;
        chk("csum_bad", {28'd0, err, cpu_rst, done, bus.in_ready}, {28'd0, 4'b1000});
        gap(2);
        chk("csum_bad_hold", {30'd0, err, cpu_rst}, {30'd0, 2'b10});
        do_start();
        send_byte(8'h01, 1'b0, s);
        send_byte(8'h5A, 1'b1, s);
        send_byte(8'h5A, 1'b0, s);
        bus.in_valid = 1'b0;
        chk("csum_recover", {29'd0, done, cpu_rst, err}, {29'd0, 3'b110});
        gap(2);
`endif

        // Reset mid-load after two of five data bytes.
        do_start();
        send_byte(8'd5, 1'b0, s);
        send_byte(8'hA1, 1'b1, s);
        send_byte(8'hB2, 1'b1, s);
        gap(1);
        chk("midrst_writes", 32'(writes), 32'd2);
        rst = 1'b0;
        #1;
        chk("midrst_outputs", {11'd0, bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_rst, done, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        gap(2);
        chk("midrst_idle", {29'd0, bus.in_ready, done, cpu_rst}, 32'd0);
        do_start();
        send_byte(8'd1, 1'b0, s);
        send_byte(8'h77, 1'b1, s);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_byte(8'h77, 1'b0, s);
`endif
        bus.in_valid = 1'b0;
        chk("midrst_reload_done", {30'd0, done, cpu_rst}, {30'd0, 2'b11});
        gap(2);
        chk("midrst_reload_writes", 32'(writes), 32'd1);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/program_loader.md
# program_loader

Boot-time program loader that fills the controller's program/data memory over a byte-wide valid/ready stream, then releases the controller from reset. It is the hardware writer for the memory the controller fetches from, and replaces file-based preloading of that memory on silicon. The block sits between the external byte source and the controller's memory write port and reset input.

## Interface
- `ADDR_W`, 8: memory address width. Memory depth is 2**`ADDR_W`.
- `DATA_W`, 8: memory word and stream byte width.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  `DATA_W`  stream byte.
- `in_ready`  out  1  loader can accept a byte (registered).
- `mem_we`  out  1  memory write strobe, one cycle per word.
- `mem_addr`  out  `ADDR_W`  memory write address.
- `mem_wdata`  out  `DATA_W`  memory write data.
- `cpu_rst`  out  1  active-low reset to the controller. 0 holds the controller in reset.
- `done`  out  1  load completed successfully (level).
- `err`  out  1  load failed the checksum (level).

## Operation
- Stream format: length byte L, then data bytes, then an optional checksum byte.
  - L = 0 means 2**`ADDR_W` data bytes. Otherwise L data bytes follow.
  - Data bytes are written to addresses 0, 1, 2, … in order.
- Handshake: a byte transfers on a rising edge where `in_valid` and `in_ready` are both 1. `in_data` is ignored when no transfer occurs.
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
  - IDLE: `in_ready` = 0 and `cpu_rst` = 0. `start` moves to LEN.
  - LEN: `in_ready` = 1. On transfer, latch the length into the remaining count, clear the address counter and the running sum, then go to DATA.
  - DATA: `in_ready` = 1. On each transfer, the next cycle drives `mem_we` = 1, `mem_addr` = address counter, `mem_wdata` = byte. Then increment the address, add the byte to the 8-bit running sum (mod 256), and decrement the count.
  - When the final data byte transfers, go to CSUM if checksums are compiled in, otherwise go to DONE.
  - CSUM: `in_ready` = 1. On transfer, go to DONE if the byte equals the running sum, otherwise go to ERR.
  - DONE: `done` = 1, `cpu_rst` = 1, `in_ready` = 0.
  - ERR: `err` = 1, `cpu_rst` = 0, `in_ready` = 0.
- `start` behaviour by state:
  - In DONE or ERR: clear `done`/`err`, drive `cpu_rst` = 0, go to LEN. The controller is re-held in reset for the reload.
  - In LEN, DATA or CSUM: ignored.
- Address counter is `ADDR_W` bits and wraps to 0 only after a full-depth load (L = 0). No out-of-range address is ever driven.
- `mem_addr` and `mem_wdata` hold their last written values when `mem_we` = 0.

## Timing
- Reset values: state IDLE, `in_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_rst` 0, `done` 0, `err` 0.
- `start` at edge n gives `in_ready` = 1 from cycle n+1.
- Write latency: a byte transferred at edge k produces `mem_we` high during cycle k+1 only.
- Throughput: one byte per cycle with `in_valid` held high. No bubbles between the length, data and checksum bytes.
- The final transfer (last data byte or checksum) at edge k:
  - `in_ready` falls at k+1.
  - `done`/`cpu_rst` rise at k+1, or `err` rises at k+1.
- Without the checksum, the last `mem_we` and the `cpu_rst` release occur in the same cycle. The write commits on the same edge at which the controller leaves reset, so the first fetch sees the written data.
- Reset asserted mid-load: all outputs return to reset values immediately. Memory contents already written are not cleared.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined: CSUM state present. A trailing checksum byte is required, and a mismatch gives ERR.
- `PROGRAM_LOADER_CHECKSUM_EN` undefined: no CSUM state and no sum register. ERR is unreachable, so `err` is tied to 0, and DATA goes directly to DONE.

## Test plan
- Reset, then hold `start` = 0 for 10 cycles: all outputs stay 0 and no `mem_we` occurs.
- Checksum enabled: stream 03, 11, 22, 33, 66 back-to-back. Expect writes 0←11, 1←22, 2←33 in consecutive cycles, then `done` = 1 and `cpu_rst` = 1 one cycle after the 66 transfer.
- Checksum enabled: stream 02, 0A, 0B, 00. Expect two writes, then `err` = 1, `cpu_rst` = 0, `done` = 0. A following `start` plus a valid stream gives `done` = 1.
- Checksum disabled: L = 00 with 256 bytes whose value equals the address. Expect addresses 00..FF written exactly once each, no wrap write, and `done` in the same cycle as the write to address FF.
- Toggle `in_valid` randomly during DATA: exactly one write per handshake, addresses contiguous.
- Assert `rst` after 2 of 5 data bytes: outputs return to reset values at once. A new `start` restarts at address 0.
